// File: rtl/pwm_servo_pkg.sv
// Shared servo timing constants and capture FSM state type.
// Used by both the servo PWM generator and pwm_servo_capture.
package pwm_servo_pkg;

  localparam int unsigned MIN_CYC     = 27200;
  localparam int unsigned STEP_CYC    = 515;
  localparam int unsigned MAX_ANGLE   = 180;
  localparam int unsigned TIMEOUT_CYC = 1500000;
  localparam int unsigned FRAME_CYC   = 1000000;
  localparam int unsigned WIDTH_BITS  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    CONV = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_channel.sv
// One servo capture lane: synchronizer, optional glitch filter, width FSM,
// serial divider and stale timer. Filter enabled by PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture_channel #(
  parameter int unsigned MIN_CYC     = pwm_servo_pkg::MIN_CYC,
  parameter int unsigned STEP_CYC    = pwm_servo_pkg::STEP_CYC,
  parameter int unsigned MAX_ANGLE   = pwm_servo_pkg::MAX_ANGLE,
  parameter int unsigned TIMEOUT_CYC = pwm_servo_pkg::TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       range_err,
  output logic       stale
);
  import pwm_servo_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [18:0]   L_MIN  = 19'(MIN_CYC);
  localparam logic [18:0]   L_STEP = 19'(STEP_CYC);
  localparam logic [18:0]   L_HALF = 19'(STEP_CYC / 2);
  localparam logic [7:0]    L_MAXQ = 8'(MAX_ANGLE);
  localparam logic [TW-1:0] L_TO   = TW'(TIMEOUT_CYC);

  logic r_sync1, r_sync2, r_prev;
  logic w_lvl, w_rise, w_fall;

  // Sync and edge history reset high so a line already high at release
  // shows no rising edge until it has been low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= w_lvl;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic [2:0] r_hist;
  logic       r_filt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '1;
      r_filt <= 1'b1;
    end else begin
      r_hist <= {r_hist[1:0], r_sync2};
      if ({r_hist, r_sync2} == 4'b0000) r_filt <= 1'b0;
      else if ({r_hist, r_sync2} == 4'b1111) r_filt <= 1'b1;
    end
  end
  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync2;
`endif

  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  cap_state_t        r_state, w_next;
  logic [17:0]       r_width;
  logic [18:0]       r_rem;
  logic [7:0]        r_q;
  logic              r_low;
  logic              w_step, w_done;
  logic [TW-1:0]     r_scnt;
  logic [7:0]        r_angle;
  logic              r_valid, r_err, r_stale;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (w_rise) w_next = HIGH;
      HIGH: if (w_fall) w_next = CONV;
      CONV: begin
        if (r_rem >= L_STEP && r_q < L_MAXQ) begin
          w_step = 1'b1;
        end else begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_width <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_low   <= 1'b0;
      r_scnt  <= '0;
      r_angle <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_stale <= 1'b1;
    end else begin
      r_valid <= w_done;
      if (r_state == IDLE && w_rise)
        r_width <= 18'd1;
      else if (r_state == HIGH && r_width != '1)
        r_width <= r_width + 18'd1;

      if (r_state == HIGH && w_fall) begin
        r_q <= '0;
        if ({1'b0, r_width} < L_MIN) begin
          r_rem <= '0;
          r_low <= 1'b1;
        end else begin
          r_rem <= {1'b0, r_width} - L_MIN + L_HALF;
          r_low <= 1'b0;
        end
      end else if (w_step) begin
        r_rem <= r_rem - L_STEP;
        r_q   <= r_q + 8'd1;
      end

      if (w_done) begin
        r_angle <= r_q;
        r_err   <= r_low | (r_q == L_MAXQ && r_rem >= L_STEP);
      end

      if (w_rise)             r_scnt <= '0;
      else if (r_scnt != L_TO) r_scnt <= r_scnt + 1'b1;

      if (w_done)              r_stale <= 1'b0;
      else if (r_scnt == L_TO) r_stale <= 1'b1;
    end
  end

  assign angle       = r_angle;
  assign angle_valid = r_valid;
  assign range_err   = r_err;
  assign stale       = r_stale;

endmodule

// File: rtl/pwm_servo_capture.sv
// Multi-channel servo PWM pulse-width to angle decoder.
// Optional input glitch filter: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_servo_capture #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned MIN_CYC     = pwm_servo_pkg::MIN_CYC,
  parameter int unsigned STEP_CYC    = pwm_servo_pkg::STEP_CYC,
  parameter int unsigned MAX_ANGLE   = pwm_servo_pkg::MAX_ANGLE,
  parameter int unsigned TIMEOUT_CYC = pwm_servo_pkg::TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   pwm_in,
  output logic [NCH*8-1:0] angle,
  output logic [NCH-1:0]   angle_valid,
  output logic [NCH-1:0]   range_err,
  output logic [NCH-1:0]   stale
);
  import pwm_servo_pkg::*;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_capture_channel #(
      .MIN_CYC    (MIN_CYC),
      .STEP_CYC   (STEP_CYC),
      .MAX_ANGLE  (MAX_ANGLE),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in[g]),
      .angle      (angle[8*g +: 8]),
      .angle_valid(angle_valid[g]),
      .range_err  (range_err[g]),
      .stale      (stale[g])
    );
  end

endmodule

// File: tb/tb_pwm_servo_capture.sv
// Self-checking bench for pwm_servo_capture with scaled timing constants.
module tb_pwm_servo_capture;

  localparam int unsigned NCH   = 4;
  localparam int unsigned T_MIN = 64;
  localparam int unsigned T_STP = 5;
  localparam int unsigned T_MAX = 180;
  localparam int unsigned T_TO  = 3000;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int unsigned FLT = 4;
`else
  localparam int unsigned FLT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   pwm_in;
  logic [NCH*8-1:0] angle;
  logic [NCH-1:0]   angle_valid, range_err, stale;

  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    int unsigned ch;
    logic [7:0]  ang;
    logic        err;
    logic        stl;
    int unsigned cyc;
  } ev_t;
  ev_t evq[$];

  pwm_servo_capture #(
    .NCH(NCH), .MIN_CYC(T_MIN), .STEP_CYC(T_STP),
    .MAX_ANGLE(T_MAX), .TIMEOUT_CYC(T_TO)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .angle(angle),
    .angle_valid(angle_valid), .range_err(range_err), .stale(stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (angle_valid[c] === 1'b1) begin
        ev_t e;
        e.ch = c; e.ang = angle[8*c +: 8]; e.err = range_err[c];
        e.stl = stale[c]; e.cyc = cyc;
        evq.push_back(e);
      end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: round-to-nearest angle from width, clipped to the range.
  function automatic int unsigned exp_angle(input int unsigned w);
    int unsigned q;
    if (w < T_MIN) return 0;
    q = (w - T_MIN + T_STP / 2) / T_STP;
    return (q > T_MAX) ? T_MAX : q;
  endfunction

  function automatic bit exp_err(input int unsigned w);
    if (w < T_MIN) return 1'b1;
    return (w - T_MIN + T_STP / 2) >= (T_MAX + 1) * T_STP;
  endfunction

  task automatic get_ev(input int unsigned c, output bit ok, output ev_t e);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      for (int i = 0; i < evq.size(); i++)
        if (!ok && evq[i].ch == c) begin
          e = evq[i]; evq.delete(i); ok = 1'b1;
        end
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic drive(input int unsigned w[NCH], output int unsigned tf[NCH]);
    int unsigned mx = 0;
    for (int c = 0; c < NCH; c++) begin
      tf[c] = 0;
      if (w[c] > mx) mx = w[c];
    end
    @(negedge clk);
    for (int unsigned t = 0; t <= mx; t++) begin
      for (int c = 0; c < NCH; c++) begin
        pwm_in[c] = (t < w[c]);
        if (w[c] != 0 && t == w[c]) tf[c] = cyc;
      end
      if (t < mx) @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input int unsigned w[NCH]);
    int unsigned tf[NCH];
    bit ok;
    ev_t e;
    drive(w, tf);
    for (int c = 0; c < NCH; c++) begin
      if (w[c] == 0) continue;
      get_ev(c, ok, e);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s ch%0d valid: got none within 400 cycles, want one (w=%0d)", tag, c, w[c]);
        continue;
      end
      n_cmp++;
      if (e.ang !== 8'(exp_angle(w[c]))) begin
        n_bad++;
        $display("FAIL %s ch%0d angle: got %0d want %0d (w=%0d)", tag, c, e.ang, exp_angle(w[c]), w[c]);
      end
      n_cmp++;
      if (e.err !== exp_err(w[c])) begin
        n_bad++;
        $display("FAIL %s ch%0d range_err: got %0b want %0b (w=%0d)", tag, c, e.err, exp_err(w[c]), w[c]);
      end
      n_cmp++;
      if (e.cyc != tf[c] + exp_angle(w[c]) + 4 + FLT) begin
        n_bad++;
        $display("FAIL %s ch%0d latency: got %0d want %0d", tag, c, e.cyc - tf[c], exp_angle(w[c]) + 4 + FLT);
      end
      n_cmp++;
      if (e.stl !== 1'b0) begin
        n_bad++;
        $display("FAIL %s ch%0d stale at valid: got %0b want 0", tag, c, e.stl);
      end
    end
    repeat (4) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (w[c] == 0) continue;
      n_cmp++;
      if (angle[8*c +: 8] !== 8'(exp_angle(w[c]))) begin
        n_bad++;
        $display("FAIL %s ch%0d angle hold: got %0d want %0d", tag, c, angle[8*c +: 8], exp_angle(w[c]));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pwm_in = '0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (angle !== '0 || angle_valid !== '0 || range_err !== '0 || stale !== '1) begin
      n_bad++;
      $display("FAIL reset_state: got angle=%h valid=%b err=%b stale=%b want 0/0/0/1111",
               angle, angle_valid, range_err, stale);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_directed;
    run_and_check("dir_a", '{T_MIN, T_MIN + 90 * T_STP, T_MIN + 180 * T_STP, T_MIN + 2});
    run_and_check("dir_b", '{T_MIN + 3, T_MIN - 20, 1100, T_MIN + 903});
    run_and_check("dir_c", '{T_MIN + 902, 300, 300, 300});
  endtask

  task automatic test_random;
    int unsigned w[NCH];
    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < NCH; c++)
        w[c] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(T_MIN - 20, 990);
      run_and_check("random", w);
    end
  endtask

  task automatic test_glitch;
    int unsigned tf1, tf2, total;
    bit ok;
    ev_t e;
    total = T_MIN + 90 * T_STP;
    @(negedge clk);
    pwm_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    pwm_in[1] = 1'b0; tf1 = cyc;
    repeat (2) @(negedge clk);
    pwm_in[1] = 1'b1;
    repeat (total - 22) @(negedge clk);
    pwm_in[1] = 1'b0; tf2 = cyc;
`ifndef PWM_CAP_GLITCH_FILTER_EN
    get_ev(1, ok, e);
    n_cmp++;
    if (!ok || e.ang !== 8'd0 || e.err !== 1'b1 || e.cyc != tf1 + 4) begin
      n_bad++;
      $display("FAIL glitch_first: got ok=%0b angle=%0d err=%0b lat=%0d want 1/0/1/4",
               ok, e.ang, e.err, e.cyc - tf1);
    end
    get_ev(1, ok, e);
    n_cmp++;
    if (!ok || e.ang !== 8'(exp_angle(total - 22)) || e.err !== 1'b0 ||
        e.cyc != tf2 + exp_angle(total - 22) + 4) begin
      n_bad++;
      $display("FAIL glitch_second: got ok=%0b angle=%0d err=%0b want angle=%0d err=0",
               ok, e.ang, e.err, exp_angle(total - 22));
    end
`else
    get_ev(1, ok, e);
    n_cmp++;
    if (!ok || e.ang !== 8'd90 || e.err !== 1'b0 || e.cyc != tf2 + 90 + 4 + FLT) begin
      n_bad++;
      $display("FAIL glitch_filtered: got ok=%0b angle=%0d err=%0b want angle=90 err=0",
               ok, e.ang, e.err);
    end
    get_ev(1, ok, e);
    n_cmp++;
    if (ok) begin
      n_bad++;
      $display("FAIL glitch_extra: got extra valid angle=%0d, want none", e.ang);
    end
`endif
  endtask

  task automatic test_stale;
    repeat (T_TO + 50) @(negedge clk);
    n_cmp++;
    if (stale !== 4'b1111) begin
      n_bad++;
      $display("FAIL stale_set: got %b want 1111", stale);
    end
    run_and_check("stale_clr", '{0, 0, T_MIN + 90 * T_STP, 0});
    n_cmp++;
    if (stale !== 4'b1011) begin
      n_bad++;
      $display("FAIL stale_other: got %b want 1011", stale);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    pwm_in = 4'b1111;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    evq.delete();
    @(negedge clk);
    n_cmp++;
    if (angle !== '0 || angle_valid !== '0 || range_err !== '0 || stale !== '1) begin
      n_bad++;
      $display("FAIL midreset_state: got angle=%h valid=%b err=%b stale=%b want 0/0/0/1111",
               angle, angle_valid, range_err, stale);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    pwm_in = '0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (evq.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_novalid: got %0d valid pulses want 0", evq.size());
    end
    run_and_check("post_reset", '{T_MIN + 90 * T_STP, 0, T_MIN + 45 * T_STP, 0});
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_glitch();
    test_stale();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
